scan_pattern_applier: RTL and testbench
=======================================

Name: scan_pattern_applier

Overview:
- Synthesizable on-chip scan tester that sits directly upstream of the scan-inserted s5378 core (179-bit chain, 35 PI, 49 PO).
- Accepts one stored test pattern at a time over a valid/ready stream and applies the primary inputs.
- Shifts the pattern into the chain while unloading the previous response, samples the POs, and issues the optional capture clock.
- Compares the results against the expected values and reports a per-pattern verdict plus a running fault count.

Parameters:
CHAIN_LEN, 179, scan chain length in flops
PI_W, 35, primary input width
PO_W, 49, primary output width
SETTLE_CYC, 20, CK cycles waited after the last shift and after capture; must be >=1
IDX_W, 16, pattern index and fault counter width

Ports:
CK  in  1  system clock; all logic on rising edge
RST  in  1  synchronous, active-high reset
pat_valid  in  1  pattern available
pat_ready  out  1  block accepts pattern (handshake when valid&&ready)
pat_ck  in  1  1 = issue capture clock after load
pat_si_cap  in  1  test_si value during capture
pat_se_cap  in  1  test_se value during capture
pat_last  in  1  final pattern; triggers flush unload
pat_pi  in  PI_W  primary input vector
pat_si_vec  in  CHAIN_LEN  scan-in data; MSB shifted first
pat_exp_po  in  PO_W  expected PO
pat_exp_so  in  CHAIN_LEN  expected scan-out observed during this pattern's load
dut_pi  out  PI_W  to core PIs
dut_si  out  1  to test_si
dut_se  out  1  to test_se
dut_ck_en  out  1  one-cycle enable for the gated core clock
dut_po  in  PO_W  from core POs
dut_so  in  1  from test_so
res_valid  out  1  result available
res_ready  in  1  result consumer ready
res_idx  out  IDX_W  pattern index (0-based); for flush, the count of patterns applied
res_po_err  out  PO_W  per-bit PO mismatch mask (act^exp)
res_so_err  out  CHAIN_LEN  per-bit SO mismatch mask
res_so  out  CHAIN_LEN  unloaded vector
res_flush  out  1  result is final flush unload (no compare; masks 0)
fault_cnt  out  IDX_W  patterns with any mismatch; saturates at all-ones
done  out  1  flush reported; sticky until RST

Behaviour:
- Reset values: all outputs 0 (dut_pi, dut_si, dut_se, dut_ck_en, res_*, fault_cnt, done); pat_ready=0 during the RST cycle; FSM=IDLE; index=0.
- IDLE: pat_ready=1. On handshake: latch all pat_* fields, drive dut_pi=pat_pi, set dut_se=1, bit counter=CHAIN_LEN-1, go to SHIFT_D.
- SHIFT_D: drive dut_si=si_vec[cnt]; act_so <= {act_so[CHAIN_LEN-2:0], dut_so}; go to SHIFT_C.
- SHIFT_C: dut_ck_en=1 for exactly this cycle. If cnt==0 go to SETTLE1, else cnt--.
- Shift timing: 2 CK per bit, so the load occupies 2*CHAIN_LEN cycles. The first sampled bit ends in the act_so MSB.
- SETTLE1: dut_se stays 1; wait SETTLE_CYC cycles; then CAPT_PO.
- CAPT_PO: act_po <= dut_po. Drive dut_si=pat_si_cap, dut_se=pat_se_cap. Go to CAPT_CK if pat_ck, else SETTLE2.
- CAPT_CK: dut_ck_en=1 for one cycle; then SETTLE2.
- SETTLE2: wait SETTLE_CYC cycles; then REPORT.
- REPORT: res_valid=1 with masks = act ^ exp; hold all res_* stable until res_ready.
  - On the accept cycle, fault_cnt++ (saturating) if either mask is non-zero, and idx++.
  - Then go to FLUSH_D if the latched last flag is set, else IDLE.
- FLUSH_D/FLUSH_C: same as the shift states with dut_si=0 and dut_se=1, CHAIN_LEN bits.
- FREPORT: res_valid=1, res_flush=1, res_so=act_so, masks 0. On accept go to DONE.
- DONE: done=1, pat_ready=0. Only RST leaves DONE.
- The first pattern's exp_so corresponds to the power-up chain contents; comparison is unconditional (vector file supplies a matching value).
- pat_ready is 0 in every state except IDLE; pat_valid outside IDLE is ignored.
- RST mid-operation: abort immediately, all outputs return to reset values next cycle, fault_cnt and index cleared.
- dut_ck_en is never high for two consecutive cycles.

Decomposition:
- Package scan_tb_pkg: state enum, CHAIN_LEN/PI_W/PO_W defaults, a packed pattern struct {ck, si_cap, se_cap, last, pi, si_vec, exp_po, exp_so}.
- One sub-module, scan_shift_engine: bit counter, si drive, so sample register, ck_en pulse. Reused for the load and flush phases via a start/zero_fill/busy interface.

Test Plan:
- Loopback (dut_so tied through a 179-flop model of the chain), pattern si_vec=alternating 1010…, pat_ck=0, last=1 -> flush res_so equals si_vec; exactly 179 ck_en pulses per load; done=1.
- Two patterns, exp values generated from the model, pat_ck=1 -> both res_po_err=0 and res_so_err=0; fault_cnt=0; exactly 180 ck_en pulses per pattern.
- Inject a PO stuck-at-1 on bit 5 -> res_po_err=49'h20 for the affected patterns; fault_cnt increments once per pattern.
- Hold res_ready=0 for 50 cycles in REPORT -> res_* stable; no new pat_ready until accept.
- Assert RST during SHIFT_C at bit 90 -> next cycle all outputs 0 and FSM in IDLE; re-run the pattern with correct results.
- Force fault_cnt to all-ones with IDX_W=2, then apply a failing pattern -> counter stays 3.

Source files
------------

// File: rtl/scan_tb_pkg.sv
// rtl/scan_tb_pkg.sv - shared types and default geometry for the s5378 scan pattern applier
package scan_tb_pkg;

  localparam int DEF_CHAIN_LEN = 179;
  localparam int DEF_PI_W      = 35;
  localparam int DEF_PO_W      = 49;

  // Load and flush shifting are sequenced inside scan_shift_engine, so one state covers each.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE1,
    ST_CAPT_PO,
    ST_CAPT_CK,
    ST_SETTLE2,
    ST_REPORT,
    ST_FLUSH,
    ST_FREPORT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic                     ck;
    logic                     si_cap;
    logic                     se_cap;
    logic                     last;
    logic [DEF_PI_W-1:0]      pi;
    logic [DEF_CHAIN_LEN-1:0] si_vec;
    logic [DEF_PO_W-1:0]      exp_po;
    logic [DEF_CHAIN_LEN-1:0] exp_so;
  } pattern_t;

endpackage

// File: rtl/scan_pattern_applier_if.sv
// rtl/scan_pattern_applier_if.sv - pattern input stream and result output stream bundle
interface scan_pattern_applier_if
  import scan_tb_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int PI_W      = DEF_PI_W,
  parameter int PO_W      = DEF_PO_W,
  parameter int IDX_W     = 16
);

  logic                 pat_valid;
  logic                 pat_ready;
  logic                 pat_ck;
  logic                 pat_si_cap;
  logic                 pat_se_cap;
  logic                 pat_last;
  logic [PI_W-1:0]      pat_pi;
  logic [CHAIN_LEN-1:0] pat_si_vec;
  logic [PO_W-1:0]      pat_exp_po;
  logic [CHAIN_LEN-1:0] pat_exp_so;

  logic                 res_valid;
  logic                 res_ready;
  logic [IDX_W-1:0]     res_idx;
  logic [PO_W-1:0]      res_po_err;
  logic [CHAIN_LEN-1:0] res_so_err;
  logic [CHAIN_LEN-1:0] res_so;
  logic                 res_flush;

  modport master (
    output pat_valid, pat_ck, pat_si_cap, pat_se_cap, pat_last,
           pat_pi, pat_si_vec, pat_exp_po, pat_exp_so, res_ready,
    input  pat_ready, res_valid, res_idx, res_po_err, res_so_err,
           res_so, res_flush
  );

  modport slave (
    input  pat_valid, pat_ck, pat_si_cap, pat_se_cap, pat_last,
           pat_pi, pat_si_vec, pat_exp_po, pat_exp_so, res_ready,
    output pat_ready, res_valid, res_idx, res_po_err, res_so_err,
           res_so, res_flush
  );

endinterface

// File: rtl/scan_shift_engine.sv
// rtl/scan_shift_engine.sv - two-cycle-per-bit scan load/unload sequencer
module scan_shift_engine #(
  parameter int CHAIN_LEN = 179
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic                 start,
  input  logic                 zero_fill,
  input  logic [CHAIN_LEN-1:0] si_vec,
  input  logic                 dut_so,
  output logic                 busy,
  output logic                 last,
  output logic                 si,
  output logic                 ck_en,
  output logic [CHAIN_LEN-1:0] so_vec
);

  localparam int CW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

  logic                 active_q;
  logic                 phase_c_q;
  logic                 zero_q;
  logic [CW-1:0]        cnt_q;
  logic [CHAIN_LEN-1:0] so_q;

  // Data phase samples test_so before the clock phase shifts the chain, so the
  // first bit unloaded lands in the MSB after CHAIN_LEN shifts.
  always_ff @(posedge CK) begin
    if (RST) begin
      active_q  <= 1'b0;
      phase_c_q <= 1'b0;
      zero_q    <= 1'b0;
      cnt_q     <= '0;
      so_q      <= '0;
    end else if (!active_q) begin
      if (start) begin
        active_q  <= 1'b1;
        phase_c_q <= 1'b0;
        zero_q    <= zero_fill;
        cnt_q     <= CW'(CHAIN_LEN - 1);
      end
    end else if (!phase_c_q) begin
      so_q      <= {so_q[CHAIN_LEN-2:0], dut_so};
      phase_c_q <= 1'b1;
    end else begin
      phase_c_q <= 1'b0;
      if (cnt_q == '0) begin
        active_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign busy   = active_q;
  assign ck_en  = active_q && phase_c_q;
  assign last   = active_q && phase_c_q && (cnt_q == '0);
  assign si     = active_q && !zero_q && si_vec[cnt_q];
  assign so_vec = so_q;

endmodule

// File: rtl/scan_pattern_applier.sv
// rtl/scan_pattern_applier.sv - applies stored scan patterns to the s5378 core and grades responses
module scan_pattern_applier
  import scan_tb_pkg::*;
#(
  parameter int CHAIN_LEN  = DEF_CHAIN_LEN,
  parameter int PI_W       = DEF_PI_W,
  parameter int PO_W       = DEF_PO_W,
  parameter int SETTLE_CYC = 20,
  parameter int IDX_W      = 16
) (
  input  logic                  CK,
  input  logic                  RST,
  scan_pattern_applier_if.slave bus,
  output logic [PI_W-1:0]       dut_pi,
  output logic                  dut_si,
  output logic                  dut_se,
  output logic                  dut_ck_en,
  input  logic [PO_W-1:0]       dut_po,
  input  logic                  dut_so,
  output logic [IDX_W-1:0]      fault_cnt,
  output logic                  done
);

  localparam int SW = $clog2(SETTLE_CYC + 1);

  state_t               state_q, state_d;
  pattern_t             pat_q;
  logic [PO_W-1:0]      act_po_q;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     fault_q;
  logic [SW-1:0]        wait_q;

  logic                 eng_start, eng_zero, eng_busy, eng_last, eng_si, eng_ck_en;
  logic [CHAIN_LEN-1:0] eng_so;
  logic                 handshake, in_settle, settle_done, mismatch;
  logic [PO_W-1:0]      po_err;
  logic [CHAIN_LEN-1:0] so_err;

  scan_shift_engine #(.CHAIN_LEN(CHAIN_LEN)) u_shift (
    .CK        (CK),
    .RST       (RST),
    .start     (eng_start),
    .zero_fill (eng_zero),
    .si_vec    (pat_q.si_vec),
    .dut_so    (dut_so),
    .busy      (eng_busy),
    .last      (eng_last),
    .si        (eng_si),
    .ck_en     (eng_ck_en),
    .so_vec    (eng_so)
  );

  assign handshake   = (state_q == ST_IDLE) && bus.pat_valid;
  assign in_settle   = (state_q == ST_SETTLE1) || (state_q == ST_SETTLE2);
  assign settle_done = (wait_q == SW'(SETTLE_CYC - 1));
  assign po_err      = act_po_q ^ pat_q.exp_po;
  assign so_err      = eng_so ^ pat_q.exp_so;
  assign mismatch    = (|po_err) || (|so_err);

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      pat_q    <= '0;
      act_po_q <= '0;
      idx_q    <= '0;
      fault_q  <= '0;
      wait_q   <= '0;
    end else begin
      state_q <= state_d;
      if (handshake) begin
        pat_q <= '{ck: bus.pat_ck, si_cap: bus.pat_si_cap, se_cap: bus.pat_se_cap,
                   last: bus.pat_last, pi: bus.pat_pi, si_vec: bus.pat_si_vec,
                   exp_po: bus.pat_exp_po, exp_so: bus.pat_exp_so};
      end
      if (state_q == ST_CAPT_PO) begin
        act_po_q <= dut_po;
      end
      wait_q <= (in_settle && !settle_done) ? wait_q + 1'b1 : '0;
      if (state_q == ST_REPORT && bus.res_ready) begin
        idx_q <= idx_q + 1'b1;
        if (mismatch && !(&fault_q)) begin
          fault_q <= fault_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    eng_start      = 1'b0;
    eng_zero       = 1'b0;
    dut_si         = 1'b0;
    dut_se         = 1'b0;
    dut_ck_en      = 1'b0;
    bus.pat_ready  = 1'b0;
    bus.res_valid  = 1'b0;
    bus.res_flush  = 1'b0;
    bus.res_idx    = '0;
    bus.res_po_err = '0;
    bus.res_so_err = '0;
    bus.res_so     = '0;
    case (state_q)
      ST_IDLE: begin
        bus.pat_ready = !RST;
        if (bus.pat_valid) begin
          eng_start = 1'b1;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        dut_se    = eng_busy;
        dut_si    = eng_si;
        dut_ck_en = eng_ck_en;
        if (eng_last) state_d = ST_SETTLE1;
      end
      ST_SETTLE1: begin
        dut_se = 1'b1;
        if (settle_done) state_d = ST_CAPT_PO;
      end
      ST_CAPT_PO: begin
        dut_si  = pat_q.si_cap;
        dut_se  = pat_q.se_cap;
        state_d = pat_q.ck ? ST_CAPT_CK : ST_SETTLE2;
      end
      ST_CAPT_CK: begin
        dut_si    = pat_q.si_cap;
        dut_se    = pat_q.se_cap;
        dut_ck_en = 1'b1;
        state_d   = ST_SETTLE2;
      end
      ST_SETTLE2: begin
        dut_si = pat_q.si_cap;
        dut_se = pat_q.se_cap;
        if (settle_done) state_d = ST_REPORT;
      end
      ST_REPORT: begin
        bus.res_valid  = 1'b1;
        bus.res_idx    = idx_q;
        bus.res_po_err = po_err;
        bus.res_so_err = so_err;
        bus.res_so     = eng_so;
        if (bus.res_ready) begin
          if (pat_q.last) begin
            eng_start = 1'b1;
            eng_zero  = 1'b1;
            state_d   = ST_FLUSH;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_FLUSH: begin
        dut_se    = eng_busy;
        dut_si    = eng_si;
        dut_ck_en = eng_ck_en;
        if (eng_last) state_d = ST_FREPORT;
      end
      ST_FREPORT: begin
        bus.res_valid = 1'b1;
        bus.res_flush = 1'b1;
        bus.res_idx   = idx_q;
        bus.res_so    = eng_so;
        if (bus.res_ready) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dut_pi    = pat_q.pi;
  assign fault_cnt = fault_q;
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_scan_pattern_applier.sv
// tb/tb_scan_pattern_applier.sv - scoreboard bench for scan_pattern_applier with a loopback core model
module tb_scan_pattern_applier;

  localparam int CL  = 179;
  localparam int PIW = 35;
  localparam int POW = 49;
  localparam int IW  = 16;
  localparam int SC  = 20;

  logic CK  = 1'b0;
  logic RST = 1'b1;
  always #5 CK = ~CK;

  scan_pattern_applier_if #(.CHAIN_LEN(CL), .PI_W(PIW), .PO_W(POW), .IDX_W(IW)) bus ();
  scan_pattern_applier_if #(.CHAIN_LEN(CL), .PI_W(PIW), .PO_W(POW), .IDX_W(2))  bus2 ();

  logic [PIW-1:0] dut_pi, dut_pi2;
  logic           dut_si, dut_se, dut_ck_en, dut_si2, dut_se2, dut_ck_en2;
  logic [POW-1:0] dut_po;
  logic [POW-1:0] dut_po2 = '0;
  logic           dut_so;
  logic           dut_so2 = 1'b0;
  logic [IW-1:0]  fault_cnt;
  logic [1:0]     fault_cnt2;
  logic           done, done2;

  scan_pattern_applier #(.CHAIN_LEN(CL), .PI_W(PIW), .PO_W(POW), .SETTLE_CYC(SC), .IDX_W(IW)) dut (
    .CK(CK), .RST(RST), .bus(bus), .dut_pi(dut_pi), .dut_si(dut_si), .dut_se(dut_se),
    .dut_ck_en(dut_ck_en), .dut_po(dut_po), .dut_so(dut_so), .fault_cnt(fault_cnt), .done(done)
  );

  scan_pattern_applier #(.CHAIN_LEN(CL), .PI_W(PIW), .PO_W(POW), .SETTLE_CYC(1), .IDX_W(2)) dut2 (
    .CK(CK), .RST(RST), .bus(bus2), .dut_pi(dut_pi2), .dut_si(dut_si2), .dut_se(dut_se2),
    .dut_ck_en(dut_ck_en2), .dut_po(dut_po2), .dut_so(dut_so2), .fault_cnt(fault_cnt2), .done(done2)
  );

  // Core model: a plain shift chain clocked by the gated enable, POs a fixed function of PIs.
  logic [CL-1:0] chain = '0;
  logic          stuck5 = 1'b0;
  always @(posedge CK) begin
    if (RST) chain <= '0;
    else if (dut_ck_en && dut_se) chain <= {chain[CL-2:0], dut_si};
  end
  assign dut_so = chain[CL-1];
  assign dut_po = {dut_pi[13:0], dut_pi} | (stuck5 ? 49'h20 : 49'h0);

  int   ck_pulses = 0;
  int   double_pulse = 0;
  logic prev_ck_en = 1'b0;
  always @(posedge CK) begin
    if (dut_ck_en) ck_pulses <= ck_pulses + 1;
    if (dut_ck_en && prev_ck_en) double_pulse <= double_pulse + 1;
    prev_ck_en <= dut_ck_en;
  end

  typedef struct {
    logic [IW-1:0]  idx;
    logic [POW-1:0] po_err;
    logic [CL-1:0]  so;
    logic           flush;
    int             pulses;
  } exp_t;

  exp_t          sbq[$];
  logic [CL-1:0] pred = '0;
  int            n_applied = 0;
  int            exp_fault = 0;
  int            base = 0;
  int            checks = 0;
  int            failures = 0;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic send(input logic ck, input logic si_cap, input logic se_cap, input logic last,
                      input logic [PIW-1:0] pi, input logic [CL-1:0] si);
    exp_t e;
    bit   got = 1'b0;
    e.idx    = IW'(n_applied);
    e.po_err = stuck5 ? 49'h20 : 49'h0;
    e.so     = pred;
    e.flush  = 1'b0;
    e.pulses = ck ? CL + 1 : CL;
    sbq.push_back(e);
    bus.pat_ck     = ck;
    bus.pat_si_cap = si_cap;
    bus.pat_se_cap = se_cap;
    bus.pat_last   = last;
    bus.pat_pi     = pi;
    bus.pat_si_vec = si;
    bus.pat_exp_po = {pi[13:0], pi};
    bus.pat_exp_so = pred;
    bus.pat_valid  = 1'b1;
    pred = si;
    if (ck && se_cap) pred = {pred[CL-2:0], si_cap};
    n_applied++;
    if (last) begin
      e.idx    = IW'(n_applied);
      e.po_err = '0;
      e.so     = pred;
      e.flush  = 1'b1;
      e.pulses = CL;
      sbq.push_back(e);
      pred = '0;
    end
    for (int i = 0; i < 1000; i++) begin
      if (bus.pat_ready) begin got = 1'b1; break; end
      @(negedge CK);
    end
    if (!got) check("pat_ready_timeout", 0, 1);
    base = ck_pulses;
    @(negedge CK);
    bus.pat_valid = 1'b0;
  endtask

  task automatic recv(input int hold);
    exp_t           e;
    bit             got = 1'b0;
    logic [CL-1:0]  so_s;
    logic [POW-1:0] po_s;
    logic [IW-1:0]  idx_s;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CK);
      if (bus.res_valid) begin got = 1'b1; break; end
    end
    if (!got) begin check("res_valid_timeout", 0, 1); return; end
    if (sbq.size() == 0) begin check("scoreboard_empty", 0, 1); return; end
    e = sbq.pop_front();
    check("res_idx", bus.res_idx, e.idx);
    check("res_flush", bus.res_flush, e.flush);
    check("res_po_err", bus.res_po_err, e.po_err);
    check("res_so_err", bus.res_so_err, 0);
    check("res_so", bus.res_so, e.so);
    check("ck_en_pulses", ck_pulses - base, e.pulses);
    if (hold > 0) begin
      so_s = bus.res_so; po_s = bus.res_po_err; idx_s = bus.res_idx;
      repeat (hold) @(negedge CK);
      check("hold_valid", bus.res_valid, 1);
      check("hold_so", bus.res_so, so_s);
      check("hold_po_err", bus.res_po_err, po_s);
      check("hold_idx", bus.res_idx, idx_s);
      check("hold_pat_ready", bus.pat_ready, 0);
    end
    bus.res_ready = 1'b1;
    @(negedge CK);
    bus.res_ready = 1'b0;
    base = ck_pulses;
    if (e.flush) begin
      check("done", done, 1);
    end else begin
      if (e.po_err != 0 && exp_fault < 65535) exp_fault++;
      check("fault_cnt", fault_cnt, exp_fault);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(negedge CK);
    check("rst_pat_ready", bus.pat_ready, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_so", bus.res_so, 0);
    check("rst_ck_en", dut_ck_en, 0);
    check("rst_se", dut_se, 0);
    check("rst_si", dut_si, 0);
    check("rst_pi", dut_pi, 0);
    check("rst_fault_cnt", fault_cnt, 0);
    check("rst_done", done, 0);
    RST = 1'b0;
    pred = '0; n_applied = 0; exp_fault = 0;
    sbq.delete();
    @(negedge CK);
    check("idle_pat_ready", bus.pat_ready, 1);
  endtask

  function automatic logic [CL-1:0] rand_vec();
    logic [CL-1:0] v;
    for (int i = 0; i < CL; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  function automatic logic [PIW-1:0] rand_pi();
    logic [63:0]    r;
    logic [PIW-1:0] p;
    r = {$urandom(), $urandom()};
    p = r[PIW-1:0];
    p[5] = 1'b0;
    return p;
  endfunction

  initial begin
    logic [CL-1:0]  alt, s;
    logic [PIW-1:0] p;
    bit             hit;
    bus.pat_valid = 0; bus.pat_ck = 0; bus.pat_si_cap = 0; bus.pat_se_cap = 0; bus.pat_last = 0;
    bus.pat_pi = '0; bus.pat_si_vec = '0; bus.pat_exp_po = '0; bus.pat_exp_so = '0; bus.res_ready = 0;
    bus2.pat_valid = 0; bus2.pat_ck = 0; bus2.pat_si_cap = 0; bus2.pat_se_cap = 0; bus2.pat_last = 0;
    bus2.pat_pi = '0; bus2.pat_si_vec = '0; bus2.pat_exp_po = '0; bus2.pat_exp_so = '0; bus2.res_ready = 0;
    @(negedge CK);
    do_reset();

    for (int i = 0; i < CL; i++) alt[i] = i[0];
    send(1'b0, 1'b0, 1'b0, 1'b1, rand_pi(), alt);
    recv(0);
    recv(0);
    check("loopback_flush_so", dut.bus.res_so, 0);
    do_reset();

    send(1'b1, 1'b1, 1'b1, 1'b0, rand_pi(), rand_vec());
    recv(50);
    send(1'b1, 1'b0, 1'b1, 1'b1, rand_pi(), rand_vec());
    recv(0);
    recv(0);
    do_reset();

    stuck5 = 1'b1;
    send(1'b0, 1'b0, 1'b0, 1'b0, rand_pi(), rand_vec());
    recv(0);
    send(1'b1, 1'b1, 1'b1, 1'b1, rand_pi(), rand_vec());
    recv(0);
    recv(0);
    stuck5 = 1'b0;
    do_reset();

    p = rand_pi();
    s = rand_vec();
    send(1'b0, 1'b0, 1'b0, 1'b0, p, s);
    hit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CK);
      if (dut_ck_en && (ck_pulses - base) == 88) begin hit = 1'b1; break; end
    end
    check("reach_bit90", hit, 1);
    do_reset();
    send(1'b0, 1'b0, 1'b0, 1'b0, p, s);
    recv(0);

    for (int k = 0; k < 4; k++) begin
      hit = 1'b0;
      bus2.pat_exp_po = '1;
      bus2.pat_valid  = 1'b1;
      for (int i = 0; i < 1000; i++) begin
        if (bus2.pat_ready) begin hit = 1'b1; break; end
        @(negedge CK);
      end
      if (!hit) check("sat_pat_ready_timeout", 0, 1);
      @(negedge CK);
      bus2.pat_valid = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge CK);
        if (bus2.res_valid) begin hit = 1'b1; break; end
      end
      if (!hit) check("sat_res_valid_timeout", 0, 1);
      check("sat_po_err", bus2.res_po_err, {POW{1'b1}});
      check("sat_idx", bus2.res_idx, k[1:0]);
      bus2.res_ready = 1'b1;
      @(negedge CK);
      bus2.res_ready = 1'b0;
      check("sat_fault_cnt", fault_cnt2, (k + 1 > 3) ? 3 : k + 1);
    end

    check("ck_en_consecutive", double_pulse, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
